fifo_read_to_ready_valid_stage: RTL
===================================

# fifo_read_to_ready_valid_stage

Downstream adapter for a Kanagawa exported method's show-ahead result FIFO (`<Method>_empty_out` / `<Method>_result_out` / `<Method>_rden_in`). It pops results into a small local buffer and re-presents them as a ready/valid stream, so ready/valid consumers can attach directly to a method's return path without losing results under back-pressure. It also keeps a count of delivered results for debug and bench checks.

## Interface

Parameters:
- `WIDTH`, 32: result data width in bits.
- `DEPTH`, 4: local buffer entries; power of two, ≥2.
- `COUNT_WIDTH`, 32: width of the delivered-result counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, **active-low**: the block is in reset while `rst`==0.
- `empty_in`  in  1  upstream FIFO empty flag.
- `data_in`  in  WIDTH  upstream head entry; valid whenever `empty_in`==0 (show-ahead).
- `rden_out`  out  1  pops the upstream head this cycle.
- `valid_out`  out  1  downstream data valid.
- `data_out`  out  WIDTH  downstream data.
- `ready_in`  in  1  downstream accepts the data.
- `occupancy_out`  out  $clog2(DEPTH)+1  number of entries currently buffered.
- `delivered_out`  out  COUNT_WIDTH  number of completed downstream transfers since reset.

## Operation

- Buffer is a circular flop array:
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
  - `count` ranges 0..DEPTH.
- Pop (upstream side): `rden_out = !empty_in && (count < DEPTH)`.
  - Combinational from `empty_in` and registered `count` only; no path from `ready_in`.
  - On pop: `mem[wr_ptr] <= data_in`, `wr_ptr` increments.
- Push (downstream side): `valid_out = (count != 0)`, `data_out = mem[rd_ptr]`.
  - A transfer happens when `valid_out && ready_in`; then `rd_ptr` increments and `delivered_out` increments.
- Count update:
  - pop only: +1
  - transfer only: −1
  - both, or neither: unchanged
- Simultaneous pop and transfer with `count`==DEPTH: no pop occurs, because `rden_out` is already 0.
- Simultaneous pop and transfer with `count`==1: the new entry is written to a different slot than the one being read. Order is preserved.
- `delivered_out` wraps modulo 2^COUNT_WIDTH without saturating.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- `valid_out` never deasserts without a transfer. Once raised, `data_out` is stable until the cycle in which `ready_in` is seen high.

## Timing

- Reset state (while `rst`==0, and on the first cycle after release):
  - `count`, `wr_ptr`, `rd_ptr`, `delivered_out`: 0
  - `valid_out`, `occupancy_out`: 0
  - `rden_out`: 0, forced low during reset regardless of `empty_in`
  - `data_out`: don't-care; buffer contents are not reset
- Latency: a result popped at edge N is on `valid_out`/`data_out` in cycle N+1.
- Throughput: with `ready_in` held high and upstream non-empty, one transfer per cycle in steady state. The first result arrives after 1 cycle.
- Reset asserted mid-operation: buffered entries are discarded. Nothing in flight upstream is affected, because a pop is committed only on an edge with `rst`==1.
- `occupancy_out` equals registered `count`.

## Structure

- Shared package `kanagawa_stage_pkg`:
  - `function automatic int occ_width(int depth)` returning $clog2(depth)+1.
  - Nothing else is shared.
- Sub-module `circular_buffer_flops`, parameterised on `WIDTH` and `DEPTH`:
  - Holds the storage array and write port (`we`, `waddr`, `wdata`).
  - Provides an asynchronous read port (`raddr`, `rdata`).
- Top level holds the pointers, `count`, handshake logic and counter.

## Test plan

1. Reset hold: `rst`=0 for 10 cycles with `empty_in`=0 → `rden_out`=0 and `valid_out`=0 throughout. After release, `occupancy_out`=0 and `delivered_out`=0.
2. Streaming: upstream FIFO preloaded with 0,5,10,…,45 and `ready_in`=1 → outputs 0..45 in order, first result 1 cycle after the first pop. Then `delivered_out`=10 and `occupancy_out`=0.
3. Full back-pressure, DEPTH=4: `ready_in`=0 with upstream holding 0,5,10,15,20,25 → exactly 4 pops and `occupancy_out`=4, after which `rden_out`=0. `data_out`=0 stays stable. Raising `ready_in` drains 0..25 in order.
4. Wrap-around: 32768 values i×5 with random `ready_in` (low for 1–16 cycles, high for 1–64) → every output equals i×5 in order, and `delivered_out`=32768.
5. Simultaneous events: with `count`=1, `empty_in`=0 and `ready_in`=1 held for 20 cycles → `occupancy_out` stays at 1, and one transfer plus one pop occurs every cycle.
6. Reset mid-run: `rst`=0 while `occupancy_out`=3 → `valid_out`=0 on the next cycle and `delivered_out`=0. After release, the stream resumes from the current upstream head with no stale entries.

Source files
------------

// File: rtl/kanagawa_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kanagawa_stage_pkg
//  Description : Helpers shared by the Kanagawa method-return adapter stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package kanagawa_stage_pkg;

  // Width of an occupancy count able to represent 0..depth inclusive.
  function automatic int occ_width(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_read_to_ready_valid_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_to_ready_valid_stage_if
//  Description : Show-ahead FIFO read side plus ready/valid stream and debug
//                status of the method-return adapter stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_read_to_ready_valid_stage_if
  import kanagawa_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 32
) ();

  logic                         empty_in;
  logic [WIDTH-1:0]             data_in;
  logic                         rden_out;
  logic                         valid_out;
  logic [WIDTH-1:0]             data_out;
  logic                         ready_in;
  logic [occ_width(DEPTH)-1:0]  occupancy_out;
  logic [COUNT_WIDTH-1:0]       delivered_out;

  // Adapter side: consumes the upstream FIFO, produces the stream.
  modport master (
    input  empty_in, data_in, ready_in,
    output rden_out, valid_out, data_out, occupancy_out, delivered_out
  );

  // Environment side: upstream FIFO and downstream consumer.
  modport slave (
    output empty_in, data_in, ready_in,
    input  rden_out, valid_out, data_out, occupancy_out, delivered_out
  );

endinterface
`default_nettype wire

// File: rtl/circular_buffer_flops.sv
`default_nettype none
// ============================================================================
//  Module      : circular_buffer_flops
//  Description : Flop-based storage array with one synchronous write port and
//                one asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module circular_buffer_flops #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Capture the written entry; storage carries no reset so it maps to plain flops.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_read_to_ready_valid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_to_ready_valid_stage
//  Description : Pops a show-ahead method-result FIFO into a small circular
//                buffer and re-presents the results as a ready/valid stream,
//                counting completed downstream transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_to_ready_valid_stage
  import kanagawa_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,   // active-low, synchronous
  fifo_read_to_ready_valid_stage_if.master    bus
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = occ_width(DEPTH);
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [COUNT_WIDTH-1:0] delivered_q, delivered_d;
  logic                   pop_w;
  logic                   xfer_w;
  logic [WIDTH-1:0]       rdata_w;

  // Pop decision depends only on the upstream flag and the registered count,
  // so no combinational path exists from ready_in back to rden_out. Gating
  // with rst keeps upstream untouched while the stage is held in reset.
  assign pop_w  = rst && !bus.empty_in && (count_q < C_DEPTH);
  assign xfer_w = bus.valid_out && bus.ready_in;

  assign bus.rden_out      = pop_w;
  assign bus.valid_out     = (count_q != '0);
  assign bus.data_out      = rdata_w;
  assign bus.occupancy_out = count_q;
  assign bus.delivered_out = delivered_q;

  circular_buffer_flops #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (pop_w),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata_w)
  );

  // Next-state: pointers advance on their own events, count nets them out.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{(AW-1){1'b0}}, pop_w};
    rd_ptr_d    = rd_ptr_q + {{(AW-1){1'b0}}, xfer_w};
    delivered_d = delivered_q + {{(COUNT_WIDTH-1){1'b0}}, xfer_w};
    count_d     = count_q;
    case ({pop_w, xfer_w})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards buffered entries and clears the counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      delivered_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      delivered_q <= delivered_d;
    end
  end

endmodule
`default_nettype wire
